// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with a registered, value-keeping bus and time-limited locked ownership.
// Optional macro BUS_ARBITER_PARITY_EN adds the bus_parity output (even parity over bus+parity).
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NUM_SRC  = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC-1:0]       src_lock,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_gnt,
  output logic [WIDTH-1:0]         bus,
  output logic                     bus_valid,
  output logic [IDX_W-1:0]         bus_owner,
  output logic                     bus_locked,
  output logic                     lock_timeout
`ifdef BUS_ARBITER_PARITY_EN
  ,
  output logic                     bus_parity
`endif
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last_owner;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [NUM_SRC-1:0] r_gnt;
  logic [WIDTH-1:0]   r_bus;
  logic               r_valid;
  logic [IDX_W-1:0]   r_owner;
  logic               r_locked;
  logic               r_timeout;

  logic [WIDTH-1:0]   w_data [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign w_data[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating search: the first requester above last_owner wins, otherwise the
  // first requester at or below it, which makes last_owner the lowest priority.
  logic               w_hi_found;
  logic [IDX_W-1:0]   w_hi_idx;
  logic [WIDTH-1:0]   w_hi_data;
  logic               w_hi_lock;
  logic               w_lo_found;
  logic [IDX_W-1:0]   w_lo_idx;
  logic [WIDTH-1:0]   w_lo_data;
  logic               w_lo_lock;
  logic               w_own_req;
  logic               w_own_lock;
  logic [WIDTH-1:0]   w_own_data;

  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_hi_data  = '0;
    w_hi_lock  = 1'b0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    w_lo_data  = '0;
    w_lo_lock  = 1'b0;
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    w_own_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == int'(r_last_owner)) begin
        w_own_req  = src_req[i];
        w_own_lock = src_lock[i];
        w_own_data = w_data[i];
      end
      if (src_req[i]) begin
        if (i > int'(r_last_owner)) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = IDX_W'(i);
            w_hi_data  = w_data[i];
            w_hi_lock  = src_lock[i];
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDX_W'(i);
          w_lo_data  = w_data[i];
          w_lo_lock  = src_lock[i];
        end
      end
    end
  end

  logic               w_arb_found;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [WIDTH-1:0]   w_arb_data;
  logic               w_arb_lock;

  assign w_arb_found = w_hi_found | w_lo_found;
  assign w_arb_idx   = w_hi_found ? w_hi_idx  : w_lo_idx;
  assign w_arb_data  = w_hi_found ? w_hi_data : w_lo_data;
  assign w_arb_lock  = w_hi_found ? w_hi_lock : w_lo_lock;

  logic               w_lock_held;
  logic               w_hold_ok;
  state_t             w_state_next;
  logic [IDX_W-1:0]   w_last_owner_next;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic [NUM_SRC-1:0] w_gnt_next;
  logic [WIDTH-1:0]   w_bus_next;
  logic               w_valid_next;
  logic [IDX_W-1:0]   w_owner_next;
  logic               w_locked_next;
  logic               w_timeout_next;

  assign w_lock_held = (r_state == ST_LOCKED) && w_own_req && w_own_lock;
  assign w_hold_ok   = (r_hold_cnt < HOLD_W'(MAX_HOLD));

  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_hold_cnt_next   = r_hold_cnt;
    w_gnt_next        = '0;
    w_bus_next        = r_bus;
    w_valid_next      = 1'b0;
    w_owner_next      = r_owner;
    w_locked_next     = 1'b0;
    w_timeout_next    = 1'b0;

    if (w_lock_held && w_hold_ok) begin
      // Locked continuation: the owner keeps the bus, all other requests wait.
      w_state_next    = ST_LOCKED;
      w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
      for (int i = 0; i < NUM_SRC; i++) begin
        w_gnt_next[i] = (i == int'(r_last_owner));
      end
      w_bus_next      = w_own_data;
      w_valid_next    = 1'b1;
      w_owner_next    = r_last_owner;
      w_locked_next   = 1'b1;
    end else begin
      w_timeout_next = w_lock_held;
      if (w_arb_found) begin
        w_state_next      = w_arb_lock ? ST_LOCKED : ST_GRANT;
        w_last_owner_next = w_arb_idx;
        w_hold_cnt_next   = HOLD_W'(1);
        for (int i = 0; i < NUM_SRC; i++) begin
          w_gnt_next[i] = (i == int'(w_arb_idx));
        end
        w_bus_next        = w_arb_data;
        w_valid_next      = 1'b1;
        w_owner_next      = w_arb_idx;
      end else begin
        w_state_next    = ST_IDLE;
        w_hold_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= IDX_W'(NUM_SRC - 1);
      r_hold_cnt   <= '0;
      r_gnt        <= '0;
      r_bus        <= '0;
      r_valid      <= 1'b0;
      r_owner      <= '0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_hold_cnt   <= w_hold_cnt_next;
      r_gnt        <= w_gnt_next;
      r_bus        <= w_bus_next;
      r_valid      <= w_valid_next;
      r_owner      <= w_owner_next;
      r_locked     <= w_locked_next;
      r_timeout    <= w_timeout_next;
    end
  end

  assign src_gnt      = r_gnt;
  assign bus          = r_bus;
  assign bus_valid    = r_valid;
  assign bus_owner    = r_owner;
  assign bus_locked   = r_locked;
  assign lock_timeout = r_timeout;

`ifdef BUS_ARBITER_PARITY_EN
  // Parity follows the bus register, so it also holds while the bus keeps its value.
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_bus_next;
    end
  end

  assign bus_parity = r_parity;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_bus_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MH = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   tb_req = '0;
  logic [N-1:0]   tb_lock = '0;
  logic [N*W-1:0] tb_data = '0;

  logic [N-1:0]   src_gnt;
  logic [W-1:0]   bus;
  logic           bus_valid;
  logic [IW-1:0]  bus_owner;
  logic           bus_locked;
  logic           lock_timeout;
`ifdef BUS_ARBITER_PARITY_EN
  logic           bus_parity;
`endif

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.WIDTH(W), .NUM_SRC(N), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_req      (tb_req),
    .src_lock     (tb_lock),
    .src_data     (tb_data),
    .src_gnt      (src_gnt),
    .bus          (bus),
    .bus_valid    (bus_valid),
    .bus_owner    (bus_owner),
    .bus_locked   (bus_locked),
    .lock_timeout (lock_timeout)
`ifdef BUS_ARBITER_PARITY_EN
    ,
    .bus_parity   (bus_parity)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural reference: who owns the bus, whether that owner holds a lock, and for how long.
  int            m_last;
  int            m_hold;
  bit            m_lockst;
  logic [N-1:0]  e_gnt;
  logic [W-1:0]  e_bus;
  logic          e_valid;
  logic [IW-1:0] e_owner;
  logic          e_locked;
  logic          e_timeout;

  function automatic logic [W-1:0] data_of(int i);
    return tb_data[i*W +: W];
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_hold = 0; m_lockst = 0;
    e_gnt = '0; e_bus = '0; e_valid = 0; e_owner = '0; e_locked = 0; e_timeout = 0;
  endtask

  task automatic model_step();
    bit found;
    int w;
    found = 0; w = 0;
    e_timeout = 0;
    if (m_lockst && tb_req[m_last] && tb_lock[m_last] && m_hold < MH) begin
      m_hold   = m_hold + 1;
      e_gnt    = N'(1) << m_last;
      e_bus    = data_of(m_last);
      e_valid  = 1;
      e_locked = 1;
    end else begin
      if (m_lockst && tb_req[m_last] && tb_lock[m_last]) e_timeout = 1;
      for (int k = 1; k <= N; k++) begin
        if (!found && tb_req[(m_last + k) % N]) begin
          found = 1;
          w = (m_last + k) % N;
        end
      end
      e_locked = 0;
      if (found) begin
        e_gnt    = N'(1) << w;
        e_bus    = data_of(w);
        e_valid  = 1;
        e_owner  = IW'(w);
        m_last   = w;
        m_hold   = 1;
        m_lockst = tb_lock[w];
      end else begin
        e_gnt    = '0;
        e_valid  = 0;
        m_hold   = 0;
        m_lockst = 0;
      end
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {src_gnt, bus, bus_valid, bus_owner, bus_locked, lock_timeout};
  endfunction

  function automatic logic [24:0] exp_vec();
    return {e_gnt, e_bus, e_valid, e_owner, e_locked, e_timeout};
  endfunction

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic show(string name, int cyc);
    $display("txn %-10s cyc=%0d req=%b lock=%b gnt=%b bus=%h valid=%b owner=%0d locked=%b timeout=%b",
             name, cyc, tb_req, tb_lock, src_gnt, bus, bus_valid, bus_owner, bus_locked, lock_timeout);
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 25'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", dut_vec(), 25'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb_req = '0; tb_lock = '0;
    for (int c = 0; c < 3; c++) begin
      advance();
      show("reset_idle", c);
      checks++;
      if (dut_vec() !== exp_vec() || bus !== 16'h0000 || bus_owner !== 2'd0 || bus_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rr_gnt [5];
    logic [W-1:0] rr_bus [5];
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_bus = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
    tb_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tb_req  = 4'b1111;
    tb_lock = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      advance();
      show("round_rob", c);
      checks++;
      if (dut_vec() !== exp_vec() || src_gnt !== rr_gnt[c] || bus !== rr_bus[c]) begin
        failures++;
        $display("FAIL round_robin cyc=%0d got gnt=%b bus=%h exp gnt=%b bus=%h",
                 c, src_gnt, bus, rr_gnt[c], rr_bus[c]);
      end
    end
  endtask

  task automatic test_lock_timeout();
    tb_data = {16'h4444, 16'hABCD, 16'h2222, 16'h1111};
    tb_req = 4'b0010; tb_lock = 4'b0000;
    advance();
    show("to_setup", 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL timeout_setup got=%h exp=%h", dut_vec(), exp_vec());
    end
    tb_req = 4'b0101; tb_lock = 4'b0100;
    for (int c = 1; c <= 9; c++) begin
      advance();
      show("lock_to", c);
      checks++;
      if (dut_vec() !== exp_vec()
          || (c <= 8 && (src_gnt !== 4'b0100 || bus !== 16'hABCD || bus_locked !== (c >= 2) || lock_timeout !== 1'b0))
          || (c == 9 && (src_gnt !== 4'b0001 || lock_timeout !== 1'b1 || bus_locked !== 1'b0))) begin
        failures++;
        $display("FAIL lock_timeout cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock_release();
    tb_req = 4'b0001; tb_lock = 4'b0000;
    advance();
    tb_req = 4'b1010; tb_lock = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) tb_lock = 4'b0000;
      advance();
      show("lock_rel", c);
      checks++;
      if (dut_vec() !== exp_vec()
          || (c <= 3 && src_gnt !== 4'b0010)
          || (c == 4 && (src_gnt !== 4'b1000 || lock_timeout !== 1'b0 || bus_locked !== 1'b0))) begin
        failures++;
        $display("FAIL lock_release cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_keeper();
    tb_data = {16'h4444, 16'h3333, 16'h5A5A, 16'h1111};
    tb_req = 4'b0010; tb_lock = 4'b0000;
    advance();
    show("keeper", 0);
    checks++;
    if (dut_vec() !== exp_vec() || bus !== 16'h5A5A || bus_owner !== 2'd1) begin
      failures++;
      $display("FAIL keeper_grant got=%h exp=%h", dut_vec(), exp_vec());
    end
    tb_req = '0;
    for (int c = 1; c <= 2; c++) begin
      tb_data = {$urandom, $urandom};
      advance();
      show("keeper", c);
      checks++;
      if (dut_vec() !== exp_vec() || bus_valid !== 1'b0 || bus !== 16'h5A5A || bus_owner !== 2'd1) begin
        failures++;
        $display("FAIL keeper_hold cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef BUS_ARBITER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] pdata [2];
    logic         ppar [2];
    pdata = '{16'h0007, 16'h0003};
    ppar  = '{1'b1, 1'b0};
    tb_req = 4'b0001; tb_lock = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tb_data = {48'h0, pdata[c]};
      advance();
      show("parity", c);
      checks++;
      if (dut_vec() !== exp_vec() || bus_parity !== ppar[c] || bus_parity !== ^e_bus) begin
        failures++;
        $display("FAIL parity cyc=%0d got=%b exp=%b", c, bus_parity, ppar[c]);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    tb_data = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
    tb_req = 4'b0001; tb_lock = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      advance();
      show("pre_reset", c);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    show("async_rst", 0);
    checks++;
    if (dut_vec() !== 25'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(), 25'h0);
    end
    tb_req = '0; tb_lock = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL post_reset got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) begin
        tb_req  = N'($urandom);
        tb_lock = N'($urandom);
      end
      tb_data = {$urandom, $urandom};
      advance();
      show("random", c);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if ($countones(src_gnt) > 1 || bus_valid !== (|src_gnt) || (bus_locked && !bus_valid)) begin
        failures++;
        $display("FAIL invariant cyc=%0d gnt=%b valid=%b locked=%b", c, src_gnt, bus_valid, bus_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_timeout();
    test_lock_release();
    test_keeper();
`ifdef BUS_ARBITER_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
